// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-style bus arbiter for mips_cpu_bus: m0 = instruction fetch, m1 = load/store.
// Optional macro MIPS_BUS_ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of fixed m1 priority.
module mips_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned TO_W           = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant,
  output logic        bus_timeout
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e          state_q;
  logic            last_grant_q;  // 1 = m1 was granted last
  logic [TO_W-1:0] stall_q;
  logic [TO_W-1:0] stall_d;
  logic            bus_timeout_q;

  logic m0_req;
  logic m1_req;
  logic own_req;
  logic tie_m1;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
  assign tie_m1 = ~last_grant_q;
`else
  logic unused_last_grant;
  assign tie_m1            = 1'b1;
  assign unused_last_grant = last_grant_q;
`endif

  assign stall_d     = stall_q + TO_W'(1);
  assign grant       = 2'(state_q);
  assign bus_timeout = bus_timeout_q;

  always_comb begin
    own_req = 1'b0;
    case (state_q)
      OWN0:    own_req = m0_req;
      OWN1:    own_req = m1_req;
      default: own_req = 1'b0;
    endcase
  end

  // Arbitration FSM, last-grant tracking and stall watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      stall_q       <= '0;
      bus_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          stall_q <= '0;
          if (m1_req && (!m0_req || tie_m1)) begin
            state_q      <= OWN1;
            last_grant_q <= 1'b1;
          end else if (m0_req) begin
            state_q      <= OWN0;
            last_grant_q <= 1'b0;
          end
        end
        OWN0, OWN1: begin
          if (!own_req || !waitrequest) begin
            state_q <= IDLE;
            stall_q <= '0;
          end else if (TIMEOUT_CYCLES != 0 && stall_q != TO_LIM) begin
            stall_q <= stall_d;
            if (stall_d == TO_LIM) bus_timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          stall_q <= '0;
        end
      endcase
    end
  end

  // Bus mux follows the owner; write wins over a simultaneous read.
  always_comb begin
    address        = '0;
    read           = 1'b0;
    write          = 1'b0;
    writedata      = '0;
    byteenable     = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    case (state_q)
      OWN0: begin
        address        = m0_address;
        read           = m0_read & ~m0_write;
        write          = m0_write;
        writedata      = m0_writedata;
        byteenable     = m0_byteenable;
        m0_waitrequest = ~(m0_req & ~waitrequest);
        m0_readdata    = readdata;
      end
      OWN1: begin
        address        = m1_address;
        read           = m1_read & ~m1_write;
        write          = m1_write;
        writedata      = m1_writedata;
        byteenable     = m1_byteenable;
        m1_waitrequest = ~(m1_req & ~waitrequest);
        m1_readdata    = readdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: reset, single transfer, tie-break, stalls, watchdog, async reset.
module tb_mips_bus_arbiter;

`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
  localparam bit FIRST_M1 = 1'b0;
`else
  localparam bit FIRST_M1 = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;
  logic [1:0]  grant;
  logic        bus_timeout;

  int vectors     = 0;
  int miscompares = 0;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(8), .TO_W(10)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .grant(grant), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_read"},  32'(read),  32'h0);
    chk({tag, "_write"}, 32'(write), 32'h0);
    chk({tag, "_m0wr"},  32'(m0_waitrequest), 32'h1);
    chk({tag, "_m1wr"},  32'(m1_waitrequest), 32'h1);
  endtask

  initial begin
    reset = 1'b1;
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
    waitrequest = 1'b0; readdata = '0;

    // Reset values, then five idle cycles after release.
    tick(); tick();
    chk_idle("rst");
    chk("rst_m0rd", m0_readdata, 32'h0);
    chk("rst_addr", address, 32'h0);
    chk("rst_to", 32'(bus_timeout), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("idle");
    end

    // Simultaneous requests straight after reset: tie-break.
    m0_read = 1'b1; m0_address = 32'h0000_0100;
    m1_read = 1'b1; m1_write = 1'b1; m1_address = 32'hBFC0_0010;
    m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'hF;
    waitrequest = 1'b0; readdata = 32'h5555_AAAA;
    #1 chk("tie_c0_grant", 32'(grant), 32'h0);
    tick();
    if (FIRST_M1) begin
      chk("tie1_grant", 32'(grant), 32'h2);
      chk("tie1_write", 32'(write), 32'h1);
      chk("tie1_read",  32'(read),  32'h0);
      chk("tie1_addr",  address, 32'hBFC0_0010);
      chk("tie1_wdata", writedata, 32'hDEAD_BEEF);
      chk("tie1_be",    32'(byteenable), 32'hF);
      chk("tie1_m1wr",  32'(m1_waitrequest), 32'h0);
      chk("tie1_m0wr",  32'(m0_waitrequest), 32'h1);
      m1_read = 1'b0; m1_write = 1'b0;
    end else begin
      chk("tie1_grant", 32'(grant), 32'h1);
      chk("tie1_read",  32'(read),  32'h1);
      chk("tie1_addr",  address, 32'h0000_0100);
      chk("tie1_m0wr",  32'(m0_waitrequest), 32'h0);
      chk("tie1_m1wr",  32'(m1_waitrequest), 32'h1);
      m0_read = 1'b0;
    end
    tick();
    chk("tie_gap_grant", 32'(grant), 32'h0);
    tick();
    if (FIRST_M1) begin
      chk("tie2_grant", 32'(grant), 32'h1);
      chk("tie2_read",  32'(read),  32'h1);
      chk("tie2_addr",  address, 32'h0000_0100);
      chk("tie2_m0rd",  m0_readdata, 32'h5555_AAAA);
      m0_read = 1'b0;
    end else begin
      chk("tie2_grant", 32'(grant), 32'h2);
      chk("tie2_write", 32'(write), 32'h1);
      chk("tie2_read",  32'(read),  32'h0);
      chk("tie2_wdata", writedata, 32'hDEAD_BEEF);
      chk("tie2_m1wr",  32'(m1_waitrequest), 32'h0);
      m1_read = 1'b0; m1_write = 1'b0;
    end
    tick();
    chk("tie_end_grant", 32'(grant), 32'h0);

    // Single zero-wait m0 fetch.
    m0_read = 1'b1; m0_address = 32'hBFC0_0000; readdata = 32'h2402_0001;
    #1 chk("f_c0_m0wr", 32'(m0_waitrequest), 32'h1);
    tick();
    chk("f_c1_grant", 32'(grant), 32'h1);
    chk("f_c1_addr",  address, 32'hBFC0_0000);
    chk("f_c1_m0wr",  32'(m0_waitrequest), 32'h0);
    chk("f_c1_m0rd",  m0_readdata, 32'h2402_0001);
    chk("f_c1_m1rd",  m1_readdata, 32'h0);
    m0_read = 1'b0;
    tick();
    chk("f_c2_grant", 32'(grant), 32'h0);
    chk("f_c2_m0rd",  m0_readdata, 32'h0);

    // m1 read stalled by the bus for three owned cycles.
    m1_read = 1'b1; m1_address = 32'h0000_0040; waitrequest = 1'b1; readdata = 32'h1111_2222;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("st_grant", 32'(grant), 32'h2);
      chk("st_m1wr",  32'(m1_waitrequest), 32'h1);
      if (i < 2) tick();
    end
    tick();
    waitrequest = 1'b0;
    #1;
    chk("st4_m1wr", 32'(m1_waitrequest), 32'h0);
    chk("st4_m1rd", m1_readdata, 32'h1111_2222);
    chk("st4_to",   32'(bus_timeout), 32'h0);
    m1_read = 1'b0;
    tick();
    chk("st_end_grant", 32'(grant), 32'h0);
    chk("st_end_to",    32'(bus_timeout), 32'h0);

    // Stuck bus: watchdog sets after eight stalled cycles, sticky.
    m0_write = 1'b1; m0_address = 32'h0000_0200; m0_writedata = 32'h0BAD_F00D;
    m0_byteenable = 4'h3; waitrequest = 1'b1;
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("wd_pre_to", 32'(bus_timeout), 32'h0);
    end
    tick();
    chk("wd_8_to", 32'(bus_timeout), 32'h1);
    tick(); tick();
    chk("wd_hold_to",    32'(bus_timeout), 32'h1);
    chk("wd_hold_grant", 32'(grant), 32'h1);
    chk("wd_hold_write", 32'(write), 32'h1);
    waitrequest = 1'b0;
    #1 chk("wd_done_m0wr", 32'(m0_waitrequest), 32'h0);
    m0_write = 1'b0;
    tick();
    chk("wd_after_grant", 32'(grant), 32'h0);
    chk("wd_after_to",    32'(bus_timeout), 32'h1);

    // Asynchronous reset during a stalled m1 write.
    m1_write = 1'b1; m1_address = 32'h0000_0300; m1_writedata = 32'h1234_5678;
    m1_byteenable = 4'hF; waitrequest = 1'b1;
    tick(); tick();
    chk("ar_pre_write", 32'(write), 32'h1);
    reset = 1'b1;
    #1;
    chk("ar_write", 32'(write), 32'h0);
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_to",    32'(bus_timeout), 32'h0);
    chk("ar_m1wr",  32'(m1_waitrequest), 32'h1);
    m1_write = 1'b0; waitrequest = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk_idle("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
